// File: rtl/pwm_audio_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pwm_audio_decoder_pkg                                              |
// | Brief  : Shared defaults, word field offsets and FSM states for the decoder |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
package pwm_audio_decoder_pkg;

    localparam int APU_DUTY_BITS = 8;
    localparam int APU_EDGE_BITS = 8;
    localparam int DUTY_LSB      = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    // The edge field sits directly above the duty field.
    function automatic int edge_lsb(input int window_bits);
        return window_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apu_sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : apu_sample_fifo                                                    |
// | Brief  : Show-ahead sample FIFO with level, full and empty flags            |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module apu_sample_fifo #(
    parameter int WIDTH      = 16,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [LOG2_DEPTH:0]   o_level
);

    localparam logic [LOG2_DEPTH:0] c_depth = {1'b1, {LOG2_DEPTH{1'b0}}};

    logic [WIDTH-1:0]       r_mem [2**LOG2_DEPTH];
    logic [LOG2_DEPTH-1:0]  r_wr_ptr;
    logic [LOG2_DEPTH-1:0]  r_rd_ptr;
    logic [LOG2_DEPTH:0]    r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_depth);
    assign o_level   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_audio_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pwm_audio_decoder                                                  |
// | Brief  : Measures duty and rising edges of a PWM stream per fixed window    |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module pwm_audio_decoder
    import pwm_audio_decoder_pkg::*;
#(
    parameter int WINDOW_BITS = APU_DUTY_BITS,
    parameter int EDGE_BITS   = APU_EDGE_BITS,
    parameter int FIFO_LOG2   = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_enable,
    input  logic                            i_pwm_in,
    output logic                            o_sample_valid,
    input  logic                            i_sample_ready,
    output logic [EDGE_BITS+WINDOW_BITS-1:0] o_sample_data,
    output logic [FIFO_LOG2:0]              o_fifo_level,
    output logic                            o_overflow,
    input  logic                            i_clear_ovf
);

    localparam int c_word_w   = EDGE_BITS + WINDOW_BITS;
    localparam int c_edge_lsb = edge_lsb(WINDOW_BITS);

    logic                   r_sync_meta;
    logic                   r_pwm_s;
    logic                   r_pwm_prev;
    state_t                 r_state;
    logic [WINDOW_BITS-1:0] r_wcnt;
    logic [WINDOW_BITS:0]   r_high_acc;
    logic [EDGE_BITS-1:0]   r_edge_acc;
    logic                   r_overflow;

    logic                   w_rise;
    logic                   w_last;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_drop;
    logic [WINDOW_BITS:0]   w_high_sum;
    logic [EDGE_BITS:0]     w_edge_sum;
    logic [WINDOW_BITS-1:0] w_duty;
    logic [EDGE_BITS-1:0]   w_edges;
    logic [c_word_w-1:0]    w_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_meta <= 1'b0;
            r_pwm_s     <= 1'b0;
        end else begin
            r_sync_meta <= i_pwm_in;
            r_pwm_s     <= r_sync_meta;
        end
    end

    assign w_rise     = r_pwm_s & ~r_pwm_prev;
    assign w_high_sum = r_high_acc + {{WINDOW_BITS{1'b0}}, r_pwm_s};
    assign w_edge_sum = {1'b0, r_edge_acc} + {{EDGE_BITS{1'b0}}, w_rise};
    // An all-high window would read 2^WINDOW_BITS; clamp it to all-ones.
    assign w_duty     = w_high_sum[WINDOW_BITS] ? '1 : w_high_sum[WINDOW_BITS-1:0];
    assign w_edges    = w_edge_sum[EDGE_BITS] ? '1 : w_edge_sum[EDGE_BITS-1:0];
    assign w_last     = (r_state == ST_MEAS) && i_enable && (r_wcnt == '1);

    always_comb begin
        w_word = '0;
        w_word[c_edge_lsb +: EDGE_BITS]  = w_edges;
        w_word[DUTY_LSB +: WINDOW_BITS]  = w_duty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wcnt     <= '0;
            r_high_acc <= '0;
            r_edge_acc <= '0;
            r_pwm_prev <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wcnt     <= '0;
                    r_high_acc <= '0;
                    r_edge_acc <= '0;
                    r_pwm_prev <= 1'b0;
                    if (i_enable) begin
                        r_state <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (!i_enable) begin
                        r_state    <= ST_IDLE;
                        r_wcnt     <= '0;
                        r_high_acc <= '0;
                        r_edge_acc <= '0;
                        r_pwm_prev <= 1'b0;
                    end else begin
                        // prev keeps tracking across windows so boundary edges count.
                        r_pwm_prev <= r_pwm_s;
                        r_wcnt     <= r_wcnt + 1'b1;
                        if (w_last) begin
                            r_high_acc <= '0;
                            r_edge_acc <= '0;
                        end else begin
                            r_high_acc <= w_high_sum;
                            r_edge_acc <= w_edges;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sample_valid = ~w_empty;
    assign w_pop          = o_sample_valid & i_sample_ready;
    assign w_drop         = w_last & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_overflow = r_overflow;

    apu_sample_fifo #(
        .WIDTH      (c_word_w),
        .LOG2_DEPTH (FIFO_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_last),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_data  (o_sample_data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (o_fifo_level)
    );

endmodule
`default_nettype wire
